// File: rtl/key_entry_conditioner_if.sv
// Button/switch inputs and key/password outputs of key_entry_conditioner.
// PressCount exists only when PRESS_COUNT_EN is defined.
interface key_entry_conditioner_if;
    logic       Btn1;
    logic       Btn2;
    logic [3:0] Sw;
    logic       Key1;
    logic       Key2;
    logic [3:0] Password;
    logic [1:0] State;
`ifdef PRESS_COUNT_EN
    logic [7:0] PressCount;
`endif

    modport master (
        output Btn1, Btn2, Sw,
`ifdef PRESS_COUNT_EN
        input  PressCount,
`endif
        input  Key1, Key2, Password, State
    );

    modport slave (
        input  Btn1, Btn2, Sw,
`ifdef PRESS_COUNT_EN
        output PressCount,
`endif
        output Key1, Key2, Password, State
    );
endinterface

// File: rtl/key_entry_conditioner.sv
// Synchronizes/debounces two buttons + switch bank into one-cycle key pulses.
// Optional PRESS_COUNT_EN adds a saturating 8-bit PressCount output.
module key_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic                    Clk,
    input logic                    Reset_n,
    key_entry_conditioner_if.slave kif
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DEB_PRESS = 2'b01,
        HELD      = 2'b10,
        DEB_REL   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [5:0]       sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             key1_q, key1_d;
    logic             key2_q, key2_d;
    logic [3:0]       pwd_q, pwd_d;
`ifdef PRESS_COUNT_EN
    logic [7:0]       pcnt_q, pcnt_d;
`endif

    logic       b1, b2;
    logic [3:0] sw;
    logic       valid;
    logic       at_last;
    logic       fire;

    // Bit order {Sw, Btn2, Btn1} through two flop stages
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {kif.Sw, kif.Btn2, kif.Btn1};
            sync2_q <= sync1_q;
        end
    end

    assign b1      = sync2_q[0];
    assign b2      = sync2_q[1];
    assign sw      = sync2_q[5:2];
    assign valid   = sel_q ? (b2 && !b1) : (b1 && !b2);
    assign at_last = (cnt_q == LAST);
    assign fire    = (state_q == DEB_PRESS) && valid && at_last;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (b1 ^ b2) begin
                    state_d = DEB_PRESS;
                    cnt_d   = ONE;
                    sel_d   = b2;
                end
            end
            DEB_PRESS: begin
                if (!valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HELD: begin
                if (!(b1 || b2)) begin
                    state_d = DEB_REL;
                    cnt_d   = ONE;
                end
            end
            DEB_REL: begin
                // Any high sample during release is bounce: back to HELD
                if (b1 || b2) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        key1_d = fire && !sel_q;
        key2_d = fire && sel_q;
        pwd_d  = fire ? sw : pwd_q;
`ifdef PRESS_COUNT_EN
        pcnt_d = (fire && pcnt_q != 8'hFF) ? pcnt_q + 8'd1 : pcnt_q;
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            key1_q <= 1'b0;
            key2_q <= 1'b0;
            pwd_q  <= 4'h0;
`ifdef PRESS_COUNT_EN
            pcnt_q <= 8'h00;
`endif
        end else begin
            key1_q <= key1_d;
            key2_q <= key2_d;
            pwd_q  <= pwd_d;
`ifdef PRESS_COUNT_EN
            pcnt_q <= pcnt_d;
`endif
        end
    end

    assign kif.Key1     = key1_q;
    assign kif.Key2     = key2_q;
    assign kif.Password = pwd_q;
    assign kif.State    = state_q;
`ifdef PRESS_COUNT_EN
    assign kif.PressCount = pcnt_q;
`endif

endmodule

// File: tb/tb_key_entry_conditioner.sv
// Bench for key_entry_conditioner with DEBOUNCE_CYCLES=4.
// PRESS_COUNT_EN additionally checks PressCount.
module tb_key_entry_conditioner;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_entry_conditioner_if kif();

    key_entry_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(20)
    ) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .kif(kif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Model: a press is accepted on the N-th consecutive synchronized
    // sample where one button alone is high; re-arming needs N
    // consecutive all-low samples afterwards.
    logic [5:0] p1 = '0, p2 = '0;
    bit         armed = 1;
    int         run = 0, relrun = 0, who = 0;
    bit         mk1 = 0, mk2 = 0;
    logic [3:0] mpw = '0;
    int         mpc = 0;
    int         mstate;

    int edge_n = 0, k1n = 0, k2n = 0, last_pulse_edge = -1;
    bit tracing = 0;
    int trq[$];
    int pulses[$];

    always @(posedge clk) begin : model
        bit         b1, b2;
        logic [3:0] sw;
        edge_n++;
        b1 = p2[0];
        b2 = p2[1];
        sw = p2[5:2];
        p2 = p1;
        p1 = {kif.Sw, kif.Btn2, kif.Btn1};
        mk1 = 0;
        mk2 = 0;
        if (!rst_n) begin
            p1 = '0; p2 = '0;
            armed = 1; run = 0; relrun = 0; who = 0;
            mpw = '0; mpc = 0;
        end else if (armed) begin
            if (b1 ^ b2) begin
                if (run == 0) begin
                    who = int'(b2);
                    run = 1;
                end else if (int'(b2) == who) run++;
                else run = 0;
            end else begin
                run = 0;
            end
            if (run == N) begin
                mk1 = (who == 0);
                mk2 = (who == 1);
                mpw = sw;
                if (mpc < 255) mpc++;
                armed = 0; run = 0; relrun = 0;
            end
        end else begin
            if (b1 || b2) relrun = 0;
            else relrun++;
            if (relrun == N) begin
                armed = 1;
                relrun = 0;
            end
        end
        mstate = armed ? (run == 0 ? 0 : 1) : (relrun == 0 ? 2 : 3);
        #1;
        check("key1", kif.Key1, mk1);
        check("key2", kif.Key2, mk2);
        check("password", kif.Password, mpw);
        check("state", kif.State, mstate);
`ifdef PRESS_COUNT_EN
        check("press_count", kif.PressCount, mpc);
`endif
        if (kif.Key1 === 1'b1) k1n++;
        if (kif.Key2 === 1'b1) k2n++;
        if (kif.Key1 === 1'b1 || kif.Key2 === 1'b1) begin
            last_pulse_edge = edge_n;
            pulses.push_back(int'(kif.Key2) * 16 + int'(kif.Password));
        end
        if (tracing) trq.push_back(int'(kif.State));
    end

    task automatic step(bit a, bit b, logic [3:0] s, int n);
        kif.Btn1 = a;
        kif.Btn2 = b;
        kif.Sw   = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0, k1b, k2b;
        int cq[$];
        int exp_tr[5] = '{2, 3, 2, 3, 0};
        int exp_p[4]  = '{13, 23, 9, 21};
        kif.Btn1 = 0;
        kif.Btn2 = 0;
        kif.Sw   = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_state", kif.State, 0);
        check("reset_pwd", kif.Password, 0);
        rst_n = 1'b1;

        // Bouncing Btn2 never completes a press
        k2b = k2n;
        step(0, 1, 4'h7, 2);
        step(0, 0, 4'h7, 1);
        step(0, 1, 4'h7, 2);
        step(0, 0, 4'h7, 10);
        check("bounce_no_key2", k2n - k2b, 0);
        check("bounce_state", kif.State, 0);
        check("bounce_pwd", kif.Password, 0);

        // Clean Btn1 press: pulse after edge N+2
        e0 = edge_n; k1b = k1n; k2b = k2n;
        step(1, 0, 4'hD, 12);
        step(0, 0, 4'hD, 10);
        check("t1_key1_count", k1n - k1b, 1);
        check("t1_pulse_edge", last_pulse_edge - e0, 6);
        check("t1_no_key2", k2n - k2b, 0);
        check("t1_pwd", kif.Password, 13);

        // Simultaneous and staggered two-button presses rejected
        k1b = k1n; k2b = k2n;
        step(1, 1, 4'h3, 10);
        step(0, 0, 4'h3, 8);
        step(1, 0, 4'h3, 2);
        step(1, 1, 4'h3, 6);
        step(0, 0, 4'h3, 8);
        check("t3_no_pulse", (k1n - k1b) + (k2n - k2b), 0);
        check("t3_state", kif.State, 0);

        // Long Btn2 hold then release glitch
        k2b = k2n;
        step(0, 1, 4'h9, 50);
        trq.delete();
        tracing = 1;
        step(0, 0, 4'h9, 2);
        step(0, 1, 4'h9, 1);
        step(0, 0, 4'h9, 10);
        tracing = 0;
        check("t4_key2_count", k2n - k2b, 1);
        check("t4_pwd", kif.Password, 9);
        foreach (trq[i])
            if (cq.size() == 0 || cq[cq.size()-1] != trq[i]) cq.push_back(trq[i]);
        check("t4_trace_len", cq.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t4_trace", (i < cq.size()) ? cq[i] : 99, exp_tr[i]);

        // Reset while DEB_PRESS with cnt=2
        k1b = k1n;
        step(1, 0, 4'h6, 4);
        check("t5_pre_state", kif.State, 1);
        rst_n = 1'b0;
        step(0, 0, 4'h6, 1);
        check("t5_state", kif.State, 0);
        check("t5_key1", kif.Key1, 0);
        check("t5_key2", kif.Key2, 0);
        check("t5_pwd", kif.Password, 0);
        rst_n = 1'b1;
        step(0, 0, 4'h6, 12);
        check("t5_no_pulse", k1n - k1b, 0);

        // Four-key sequence
        pulses.delete();
        step(1, 0, 4'd13, 8); step(0, 0, 4'd13, 8);
        step(0, 1, 4'd7, 8);  step(0, 0, 4'd7, 8);
        step(1, 0, 4'd9, 8);  step(0, 0, 4'd9, 8);
        step(0, 1, 4'd5, 8);  step(0, 0, 4'd5, 8);
        check("t6_pulse_count", pulses.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t6_pulse", (i < pulses.size()) ? pulses[i] : 99, exp_p[i]);
`ifdef PRESS_COUNT_EN
        check("t6_press_count", kif.PressCount, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
